if_fetch_unit: RTL

- Instruction-fetch stage of the MIPS pipeline CPU.
- Owns the F-stage PC and consumes the redirect target produced by the D-stage next-PC select logic.
- Drives a req/ack instruction-memory port and delivers (PC, instruction) pairs into the IF/ID pipeline register.
- Honours hazard-unit stalls through a one-entry hold buffer and implements MIPS branch-delay-slot semantics.

---
 rtl/if_fetch_unit.sv | 84 ++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: MIPS F stage with req/ack instruction fetch, one-entry stall hold buffer and delay-slot redirect.
module if_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              im_req,
    output logic [ADDR_W-1:0] im_addr,
    input  logic              im_ack,
    input  logic [31:0]       im_rdata,
    output logic [ADDR_W-1:0] D_PC,
    output logic [31:0]       D_Instr,
    output logic              D_valid
);
    typedef enum logic {FETCH, HOLD} state_t;

    localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(3);

    state_t            state;
    logic [ADDR_W-1:0] f_pc;
    logic [ADDR_W-1:0] redir_tgt;
    logic              redir_pend;
    logic [ADDR_W-1:0] buf_pc;
    logic [31:0]       buf_instr;
    logic              adv;
    logic [ADDR_W-1:0] tgt;
    logic [ADDR_W-1:0] next_pc;

    // Request is gated by rst_n so an in-flight fetch is abandoned the instant reset asserts.
    assign im_req  = rst_n && state == FETCH;
    assign im_addr = f_pc;

    always_comb begin
        adv     = !stall && (state == HOLD || im_ack);
        tgt     = redirect_pc & ALIGN;
        next_pc = redirect ? tgt : redir_pend ? redir_tgt : f_pc + ADDR_W'(4);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            f_pc       <= RESET_PC & ALIGN;
            redir_pend <= 1'b0;
            redir_tgt  <= '0;
            buf_pc     <= '0;
            buf_instr  <= '0;
            D_PC       <= '0;
            D_Instr    <= '0;
            D_valid    <= 1'b0;
        end else begin
            // The PC only moves when an instruction enters D, so a redirect seen earlier waits for the delay slot.
            if (adv) begin
                f_pc       <= next_pc;
                redir_pend <= 1'b0;
            end else if (redirect) begin
                redir_pend <= 1'b1;
                redir_tgt  <= tgt;
            end
            if (state == FETCH) begin
                if (im_ack && stall) begin
                    buf_pc    <= f_pc;
                    buf_instr <= im_rdata;
                    state     <= HOLD;
                end
                if (!stall) begin
                    D_valid <= im_ack;
                    if (im_ack) begin
                        D_PC    <= f_pc;
                        D_Instr <= im_rdata;
                    end
                end
            end else if (!stall) begin
                D_PC    <= buf_pc;
                D_Instr <= buf_instr;
                D_valid <= 1'b1;
                state   <= FETCH;
            end
        end
    end
endmodule
